processor: RTL and testbench

Multi-cycle 8-bit accumulator-less register processor with an 8-bit program counter, four general registers and Z/C flags. It fetches one instruction byte per fetch cycle from an external instruction memory addressed by `counter_out`, and accesses a separate 256-byte data memory through a read/write request interface. It is the top-level compute block; both memories are external.

---
 rtl/processor_pkg.sv | 43 ++++
 rtl/processor_alu.sv | 38 +++
 rtl/processor.sv | 157 +++++++++++++++
 tb/tb_processor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared definitions for the processor: opcodes, jump conditions, FSM states
// and data-memory function codes. PROCESSOR_SHIFT_EN enables SHL/SHR.
package processor_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_MOV = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_LD  = 4'hB;
    localparam logic [3:0] OP_ST  = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;
    localparam logic [3:0] OP_JCC = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] CC_Z  = 2'b00;
    localparam logic [1:0] CC_NZ = 2'b01;
    localparam logic [1:0] CC_C  = 2'b10;
    localparam logic [1:0] CC_NC = 2'b11;

    localparam logic [1:0] MEM_IDLE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_IMM   = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    // Two-byte instructions carry an immediate or target address.
    function automatic logic needs_imm(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JCC);
    endfunction

endpackage

// File: rtl/processor_alu.sv
// Combinational ALU: result, zero and carry/borrow for register-register ops.
// Shifter only built when PROCESSOR_SHIFT_EN is defined.
module processor_alu
    import processor_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [3:0] i_op,
    output logic [7:0] o_result,
    output logic       o_z,
    output logic       o_c
);

    logic [8:0] w_wide;

    // Bit 8 carries carry-out, borrow, or the bit shifted out; zero for logic ops.
    always_comb begin
        w_wide = 9'd0;
        case (i_op)
            OP_MOV: w_wide = {1'b0, i_b};
            OP_ADD: w_wide = {1'b0, i_a} + {1'b0, i_b};
            OP_SUB: w_wide = {1'b0, i_a} - {1'b0, i_b};
            OP_AND: w_wide = {1'b0, i_a & i_b};
            OP_OR:  w_wide = {1'b0, i_a | i_b};
            OP_XOR: w_wide = {1'b0, i_a ^ i_b};
            OP_NOT: w_wide = {1'b0, ~i_a};
`ifdef PROCESSOR_SHIFT_EN
            OP_SHL: w_wide = {i_a, 1'b0};
            OP_SHR: w_wide = {i_a[0], 1'b0, i_a[7:1]};
`endif
            default: w_wide = {1'b0, i_a};
        endcase
        o_result = w_wide[7:0];
        o_c      = w_wide[8];
        o_z      = (w_wide[7:0] == 8'd0);
    end

endmodule

// File: rtl/processor.sv
// Multi-cycle 8-bit register processor: FETCH/EXEC/IMM/HALT FSM, four registers,
// Z/C flags, external instruction and data memories. PROCESSOR_SHIFT_EN enables SHL/SHR.
module processor
    import processor_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic [7:0] memory_read,
    output logic [7:0] counter_out,
    output logic [1:0] memory_function,
    output logic [7:0] memory_request,
    output logic [7:0] memory_write_address,
    output logic [7:0] memory_write
);

    state_t          r_state;
    state_t          w_next_state;
    logic [7:0]      r_pc;
    logic [7:0]      r_ir;
    logic [3:0][7:0] r_regs;
    logic            r_z;
    logic            r_c;

    logic [3:0] w_op;
    logic [1:0] w_rd;
    logic [1:0] w_rs;
    logic [7:0] w_alu_result;
    logic       w_alu_z;
    logic       w_alu_c;
    logic       w_alu_wb;
    logic       w_alu_flags;
    logic       w_taken;

    assign w_op = r_ir[7:4];
    assign w_rd = r_ir[3:2];
    assign w_rs = r_ir[1:0];

    processor_alu u_alu (
        .i_a      (r_regs[w_rd]),
        .i_b      (r_regs[w_rs]),
        .i_op     (w_op),
        .o_result (w_alu_result),
        .o_z      (w_alu_z),
        .o_c      (w_alu_c)
    );

    always_comb begin
        w_alu_wb    = 1'b0;
        w_alu_flags = 1'b0;
        case (w_op)
            OP_MOV: w_alu_wb = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                w_alu_wb    = 1'b1;
                w_alu_flags = 1'b1;
            end
`ifdef PROCESSOR_SHIFT_EN
            OP_SHL, OP_SHR: begin
                w_alu_wb    = 1'b1;
                w_alu_flags = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_rd)
            CC_Z:    w_taken = r_z;
            CC_NZ:   w_taken = ~r_z;
            CC_C:    w_taken = r_c;
            CC_NC:   w_taken = ~r_c;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: begin
                if (data[7:4] == OP_HLT)
                    w_next_state = ST_HALT;
                else if (needs_imm(data[7:4]))
                    w_next_state = ST_IMM;
                else
                    w_next_state = ST_EXEC;
            end
            ST_EXEC:  w_next_state = ST_FETCH;
            ST_IMM:   w_next_state = ST_FETCH;
            ST_HALT:  w_next_state = ST_HALT;
            default:  w_next_state = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_pc    <= 8'd0;
            r_ir    <= 8'd0;
            r_regs  <= '0;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_FETCH: begin
                    r_ir <= data;
                    r_pc <= r_pc + 8'd1;
                end
                ST_EXEC: begin
                    // LD captures the read data at the edge that ends EXEC.
                    if (w_op == OP_LD) begin
                        r_regs[w_rd] <= memory_read;
                        r_z          <= (memory_read == 8'd0);
                    end else if (w_alu_wb) begin
                        r_regs[w_rd] <= w_alu_result;
                        if (w_alu_flags) begin
                            r_z <= w_alu_z;
                            r_c <= w_alu_c;
                        end
                    end
                end
                ST_IMM: begin
                    if (w_op == OP_LDI) begin
                        r_regs[w_rd] <= data;
                        r_pc         <= r_pc + 8'd1;
                    end else if (w_op == OP_JMP || (w_op == OP_JCC && w_taken)) begin
                        r_pc <= data;
                    end else begin
                        r_pc <= r_pc + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign counter_out = r_pc;

    // Memory requests come only from EXEC of LD/ST; outputs read zero otherwise.
    always_comb begin
        memory_function      = MEM_IDLE;
        memory_request       = 8'd0;
        memory_write_address = 8'd0;
        memory_write         = 8'd0;
        if (r_state == ST_EXEC && w_op == OP_LD) begin
            memory_function = MEM_READ;
            memory_request  = r_regs[w_rs];
        end else if (r_state == ST_EXEC && w_op == OP_ST) begin
            memory_function      = MEM_WRITE;
            memory_write_address = r_regs[w_rs];
            memory_write         = r_regs[w_rd];
        end
    end

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor: instruction-level reference model producing
// per-cycle expected outputs, directed programs with literal pins, random programs.
`timescale 1ns/1ps
module tb_processor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic [7:0] memory_read;
    logic [7:0] counter_out;
    logic [1:0] memory_function;
    logic [7:0] memory_request;
    logic [7:0] memory_write_address;
    logic [7:0] memory_write;

    processor dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .data                 (data),
        .memory_read          (memory_read),
        .counter_out          (counter_out),
        .memory_function      (memory_function),
        .memory_request       (memory_request),
        .memory_write_address (memory_write_address),
        .memory_write         (memory_write)
    );

    always #5 clk = ~clk;

    logic [7:0] imem [256];
    logic [7:0] dmem [256];
    assign data        = imem[counter_out];
    assign memory_read = dmem[memory_request];

    // Reference model state (instruction level).
    logic [7:0]  m_pc;
    logic [7:0]  m_r [4];
    logic        m_z, m_c, m_halt;
    logic [7:0]  m_dmem [256];
    logic [33:0] exp_q [$];

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_writes;
    logic [7:0] first_wdata, last_waddr, last_wdata, last_rreq;

    function automatic logic [33:0] rec(input logic [7:0] pc, input logic [1:0] fn,
                                        input logic [7:0] req, input logic [7:0] wa,
                                        input logic [7:0] wd);
        return {pc, fn, req, wa, wd};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_result(input logic [1:0] rd, input logic [7:0] r);
        m_r[rd] = r;
        m_z     = (r == 8'd0);
    endtask

    // Execute one instruction in the model, queueing the outputs of each cycle it spans.
    task automatic model_instr();
        logic [7:0] ib, a, b;
        logic [3:0] op;
        logic [1:0] rd, rs;
        logic       taken;
        if (m_halt) begin
            exp_q.push_back(rec(m_pc, 2'b00, 8'd0, 8'd0, 8'd0));
            return;
        end
        ib = imem[m_pc];
        exp_q.push_back(rec(m_pc, 2'b00, 8'd0, 8'd0, 8'd0));
        m_pc = m_pc + 8'd1;
        op = ib[7:4]; rd = ib[3:2]; rs = ib[1:0];
        a = m_r[rd]; b = m_r[rs];
        if (op == 4'hF) begin
            m_halt = 1'b1;
            return;
        end
        if (op == 4'hB)
            exp_q.push_back(rec(m_pc, 2'b01, b, 8'd0, 8'd0));
        else if (op == 4'hC)
            exp_q.push_back(rec(m_pc, 2'b10, 8'd0, b, a));
        else
            exp_q.push_back(rec(m_pc, 2'b00, 8'd0, 8'd0, 8'd0));
        case (op)
            4'h1: begin m_r[rd] = imem[m_pc]; m_pc = m_pc + 8'd1; end
            4'h2: m_r[rd] = b;
            4'h3: begin m_c = (int'(a) + int'(b)) > 255; set_result(rd, a + b); end
            4'h4: begin m_c = (a < b); set_result(rd, a - b); end
            4'h5: begin m_c = 1'b0; set_result(rd, a & b); end
            4'h6: begin m_c = 1'b0; set_result(rd, a | b); end
            4'h7: begin m_c = 1'b0; set_result(rd, a ^ b); end
            4'h8: begin m_c = 1'b0; set_result(rd, ~a); end
`ifdef PROCESSOR_SHIFT_EN
            4'h9: begin m_c = a[7]; set_result(rd, a << 1); end
            4'hA: begin m_c = a[0]; set_result(rd, a >> 1); end
`endif
            4'hB: begin m_r[rd] = m_dmem[b]; m_z = (m_r[rd] == 8'd0); end
            4'hC: m_dmem[b] = a;
            4'hD: m_pc = imem[m_pc];
            4'hE: begin
                taken = (rd == 2'd0) ? m_z : (rd == 2'd1) ? !m_z : (rd == 2'd2) ? m_c : !m_c;
                m_pc  = taken ? imem[m_pc] : m_pc + 8'd1;
            end
            default: ;
        endcase
    endtask

    // Compare the current cycle, then advance to the next falling edge.
    task automatic tick();
        logic [33:0] e, a;
        if (exp_q.size() == 0) model_instr();
        e = exp_q.pop_front();
        a = {counter_out, memory_function, memory_request, memory_write_address, memory_write};
        check("cycle_outputs", 64'(a), 64'(e));
        if (memory_function == 2'b10) begin
            dmem[memory_write_address] = memory_write;
            if (n_writes == 0) first_wdata = memory_write;
            last_waddr = memory_write_address;
            last_wdata = memory_write;
            n_writes++;
        end
        if (memory_function == 2'b01) last_rreq = memory_request;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, 64'({counter_out, memory_function, memory_request,
                         memory_write_address, memory_write}), 64'd0);
    endtask

    // Assert reset at a falling edge, hold across a rising edge, release at a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_async");
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_held");
        m_pc = 8'd0; m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
        for (int i = 0; i < 4; i++) m_r[i] = 8'd0;
        exp_q.delete();
        n_writes = 0; first_wdata = 8'd0; last_waddr = 8'd0; last_wdata = 8'd0; last_rreq = 8'd0;
        rst_n = 1'b1;
    endtask

    task automatic load_prog(input logic [7:0] bytes [], input logic [7:0] base);
        for (int i = 0; i < bytes.size(); i++) imem[8'(base + 8'(i))] = bytes[i];
    endtask

    initial begin
        logic [7:0] p [];
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            imem[i]   = 8'h00;
            dmem[i]   = 8'($urandom_range(0, 255));
            m_dmem[i] = dmem[i];
        end

        // LDI R0,#05; LDI R1,#FB; ADD R0,R1; ST [R1],R0; JZ #40; HLT at 0x40.
        p = '{8'h10, 8'h05, 8'h14, 8'hFB, 8'h31, 8'hC1, 8'hE0, 8'h40};
        load_prog(p, 8'h00);
        imem[8'h40] = 8'hF0;
        do_reset();
        run(6);
        check("pc_after_6_cycles", 64'(counter_out), 64'h05);
        run(14);
        check("add_store_addr", 64'(last_waddr), 64'hFB);
        check("add_store_data", 64'(last_wdata), 64'h00);
        check("jz_to_halt_pc", 64'(counter_out), 64'h41);
        check("model_add_z", 64'(m_z), 64'd1);
        check("model_add_c", 64'(m_c), 64'd1);

        // ST [R2],R3 then LD R0,[R2]; ST [R1],R0; NOP; HLT at 0x08.
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        p = '{8'h18, 8'h10, 8'h1C, 8'hAA, 8'hCE, 8'hB2, 8'hC1, 8'h00, 8'hF0};
        load_prog(p, 8'h00);
        do_reset();
        run(30);
        check("st_ld_read_addr", 64'(last_rreq), 64'h10);
        check("st_ld_first_data", 64'(first_wdata), 64'hAA);
        check("st_ld_reload_addr", 64'(last_waddr), 64'h00);
        check("st_ld_reload_data", 64'(last_wdata), 64'hAA);
        check("st_ld_write_count", 64'(n_writes), 64'd2);
        check("hlt_pc_frozen", 64'(counter_out), 64'h09);
        check("hlt_mem_idle", 64'(memory_function), 64'd0);

        // SUB 03-05, ST; JC #20; JNC #30 (not taken); LDI R0,#81; SHL R0; ST; HLT.
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        p = '{8'h10, 8'h03, 8'h14, 8'h05, 8'h41, 8'hC1, 8'hE8, 8'h20};
        load_prog(p, 8'h00);
        p = '{8'hEC, 8'h30, 8'h10, 8'h81, 8'h90, 8'hC1, 8'hF0};
        load_prog(p, 8'h20);
        do_reset();
        run(30);
        check("sub_result", 64'(first_wdata), 64'hFE);
        check("shift_store_addr", 64'(last_waddr), 64'h05);
`ifdef PROCESSOR_SHIFT_EN
        check("shl_result", 64'(last_wdata), 64'h02);
`else
        check("shl_disabled_result", 64'(last_wdata), 64'h81);
`endif
        check("jcc_path_halt_pc", 64'(counter_out), 64'h27);
        check("model_final_c", 64'(m_c), 64'd1);

        // PC wrap: JMP #FE; NOP at FE; LDI R3 at FF takes its immediate from 0x00.
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        imem[8'h00] = 8'hD0; imem[8'h01] = 8'hFE; imem[8'hFF] = 8'h1C;
        do_reset();
        run(12);
        check("wrap_halt_pc", 64'(counter_out), 64'h02);
        check("model_wrap_r3", 64'(m_r[3]), 64'hD0);

        // Random programs without HLT, with resets landing mid-instruction.
        for (int i = 0; i < 256; i++)
            imem[i] = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (cyc >= 600 && (cyc % 700) >= 600 && exp_q.size() == 1 &&
                exp_q[0][25:24] != 2'b10) begin
                do_reset();
                cyc = cyc + 200;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
